// File: rtl/sequence_recorder_16x4.sv
// sequence_recorder_16x4: records a sequence of one-hot key presses into a 16x4 memory.
// A press is stored only once per press/release cycle. A non-one-hot press is flagged
// with an error pulse and is not stored. An independent registered read port serves playback.
//
// Ports:
//   clock       system clock, all state changes on its rising edge
//   reset_n     synchronous active-low reset (memory contents are kept)
//   start       begin a new recording, clears count (level-sampled)
//   stop        abort recording, return to idle, count kept
//   buttons     debounced player keys, one-hot when valid
//   rd_address  playback read address
//   rd_data     mem[rd_address], registered, one-cycle latency, read-before-write
//   count       entries written so far, 0..16
//   recording   high while waiting for a press or a release
//   full        high once 16 entries are recorded and the keys are released
//   error       one-cycle pulse after a non-one-hot press
//   wrote       one-cycle pulse after each accepted write
module sequence_recorder_16x4 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] buttons,
    input  logic [3:0] rd_address,
    output logic [3:0] rd_data,
    output logic [4:0] count,
    output logic       recording,
    output logic       full,
    output logic       error,
    output logic       wrote
);

    typedef enum logic [1:0] {
        StIdle,
        StWaitPress,
        StWaitRelease,
        StFull
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] count_q, count_d;
    logic [3:0] rd_data_q;
    logic       error_q, error_d;
    logic       wrote_q;
    logic       we;
    logic       press_any;
    logic       press_onehot;

    logic [3:0] mem [16];

    // x & (x - 1) clears the lowest set bit; zero afterwards means at most one bit was set.
    assign press_any    = (buttons != 4'd0);
    assign press_onehot = press_any && ((buttons & (buttons - 4'd1)) == 4'd0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we      = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    count_d = 5'd0;
                    state_d = StWaitPress;
                end
            end
            StWaitPress: begin
                if (start) begin
                    count_d = 5'd0;
                end else if (stop) begin
                    state_d = StIdle;
                end else if (press_onehot) begin
                    we      = 1'b1;
                    count_d = count_q + 5'd1;
                    state_d = StWaitRelease;
                end else if (press_any) begin
                    error_d = 1'b1;
                    state_d = StWaitRelease;
                end
            end
            StWaitRelease: begin
                if (start) begin
                    count_d = 5'd0;
                    state_d = StWaitPress;
                end else if (stop) begin
                    state_d = StIdle;
                end else if (!press_any) begin
                    state_d = (count_q == 5'd16) ? StFull : StWaitPress;
                end
            end
            StFull: begin
                if (start) begin
                    count_d = 5'd0;
                    state_d = StWaitPress;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            count_q   <= 5'd0;
            error_q   <= 1'b0;
            wrote_q   <= 1'b0;
            rd_data_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            error_q   <= error_d;
            wrote_q   <= we;
            rd_data_q <= mem[rd_address];
        end
    end

    // Memory has no reset; a reset cycle must still block the write.
    always_ff @(posedge clock) begin
        if (reset_n && we) begin
            mem[count_q[3:0]] <= buttons;
        end
    end

    assign rd_data   = rd_data_q;
    assign count     = count_q;
    assign error     = error_q;
    assign wrote     = wrote_q;
    assign recording = (state_q == StWaitPress) || (state_q == StWaitRelease);
    assign full      = (state_q == StFull);

endmodule

// File: doc/sequence_recorder_16x4.md
SEQUENCE_RECORDER_16X4 -- requirements
Module: sequence_recorder_16x4

Interface
REQ-001 The block SHALL have no parameters: depth fixed at 16 entries, data width fixed at 4 bits.
REQ-002 The block SHALL use one clock and a synchronous, active-low reset; all state changes on posedge clock.
REQ-003 clock  input  1  system clock.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 start  input  1  begin a new recording; count cleared, level-sampled.
REQ-006 stop  input  1  abort recording; return to idle, count retained.
REQ-007 buttons  input  4  player keys, already debounced, one-hot when valid.
REQ-008 rd_address  input  4  playback read address.
REQ-009 rd_data  output  4  registered read data, one-cycle latency.
REQ-010 count  output  5  number of entries written, range 0..16.
REQ-011 recording  output  1  high in WAIT_PRESS and WAIT_RELEASE.
REQ-012 full  output  1  high in FULL state.
REQ-013 error  output  1  one-cycle pulse on a non-one-hot press.
REQ-014 wrote  output  1  one-cycle pulse on each accepted write.

Function
REQ-015 Storage SHALL be a 16x4 array.
REQ-016 Storage SHALL have one write port driven by the FSM and one independent synchronous read port.
REQ-017 Read: rd_data SHALL load mem[rd_address] every clock, valid one cycle after rd_address.
REQ-018 Read on the address being written in the same cycle SHALL return the old contents (read-before-write).
REQ-019 The FSM SHALL have states IDLE, WAIT_PRESS, WAIT_RELEASE, FULL.
REQ-020 IDLE: start=1 -> count<=0, next WAIT_PRESS; otherwise hold.
REQ-021 WAIT_PRESS, start=1 -> count<=0, stay in WAIT_PRESS, no write; start has priority over stop and buttons.
REQ-022 WAIT_PRESS, stop=1 -> IDLE, no write.
REQ-023 WAIT_PRESS, buttons==0 -> hold.
REQ-024 WAIT_PRESS, buttons one-hot -> mem[count[3:0]]<=buttons, count<=count+1, wrote=1 next cycle, next WAIT_RELEASE.
REQ-025 WAIT_PRESS, buttons nonzero and not one-hot -> no write, count unchanged, error=1 next cycle, next WAIT_RELEASE.
REQ-026 WAIT_RELEASE: start -> restart per REQ-021; stop -> IDLE.
REQ-027 WAIT_RELEASE, buttons==0 -> FULL if count==16, else WAIT_PRESS.
REQ-028 WAIT_RELEASE, buttons!=0 -> hold; a held or changed key SHALL NOT cause a further write.
REQ-029 FULL: start=1 -> count<=0, next WAIT_PRESS; all other inputs ignored; count stays 16, no write.
REQ-030 count SHALL never exceed 16; the write address is count[3:0], so the 16th write goes to address 15 with no wrap-around.
REQ-031 error and wrote SHALL be registered single-cycle pulses and never high together.
REQ-032 recording and full SHALL be decoded from the registered state, so they are glitch-free.

Reset
REQ-033 On reset_n=0 at posedge: state IDLE, count=0, rd_data=0, error=0, wrote=0, recording=0, full=0.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 Reset asserted mid-recording SHALL abort with no write in that cycle.
REQ-036 Reset SHALL override start, stop and buttons.

Verification
REQ-037 Reset, start, press 0001 then release, 0100 then release -> wrote pulses twice, count=2; rd_address=0 -> rd_data=0001 one cycle later; rd_address=1 -> 0100.
REQ-038 Start, 16 press/release pairs -> count=16 and full=1 after the last release; a 17th press -> no wrote, count=16, mem[15] unchanged.
REQ-039 Start, press 0011 -> error pulse one cycle, count=0, no write; release then press 1000 -> mem[0]=1000, count=1.
REQ-040 Start, hold 0010 for 10 cycles -> exactly one wrote pulse, count=1.
REQ-041 Start and 0001 asserted in the same cycle in WAIT_PRESS -> count=0, no write.
REQ-042 After 3 writes, assert stop -> IDLE, count=3; then assert reset_n=0 -> count=0, rd_data=0, and reading address 0 one cycle after release still returns the first recorded value.
